// File: rtl/cla_ctrl_pkg.sv
// Shared definitions for the nibble-serial CLA sequencer.
//   state_t    : controller FSM states
//   NIBBLE_W   : width of the reused adder slice
//   clog2_min1 : ceil(log2(v)), clamped to at least 1 bit for counter sizing
package cla_ctrl_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Elaboration-time helper; a one-nibble build still needs a 1-bit counter.
   function automatic int clog2_min1(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/dvsdclaa_1v8.sv
// 4-bit carry-lookahead adder slice.
//   a, b : nibble operands
//   cin  : carry in
//   s    : nibble sum
//   cout : carry out of bit 3
module dvsdclaa_1v8 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic [3:0] g;
   logic [3:0] p;
   logic [3:0] c;

   assign g = a & b;
   assign p = a ^ b;

   // Every carry is a flat sum of products of g/p/cin, no ripple chain.
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
   assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign s = p ^ c;

endmodule

// File: rtl/cla_nibble_serial_ctrl.sv
// Nibble-serial WIDTH-bit adder: one 4-bit CLA slice reused over WIDTH/4
// cycles, low nibble first, carry threaded through a register.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : operand handshake (a, b, cin)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
//   busy                : high while a transaction is in RUN or DONE
// WIDTH must be a multiple of 4 and at least 4.
module cla_nibble_serial_ctrl
   import cla_ctrl_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int NIB   = WIDTH / NIBBLE_W;
   localparam int CNT_W = clog2_min1(NIB);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             carry;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             a_msb;
   logic             b_msb;

   logic [NIBBLE_W-1:0] slice_s;
   logic                slice_cout;

   dvsdclaa_1v8 u_slice (
      .a    (a_sh[NIBBLE_W-1:0]),
      .b    (b_sh[NIBBLE_W-1:0]),
      .cin  (carry),
      .s    (slice_s),
      .cout (slice_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         carry     <= 1'b0;
         a_sh      <= '0;
         b_sh      <= '0;
         a_msb     <= 1'b0;
         b_msb     <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // Operand inputs are only looked at here, so X on them
               // elsewhere never reaches state.
               if (in_valid && in_ready) begin
                  a_sh     <= a;
                  b_sh     <= b;
                  carry    <= cin;
                  cnt      <= '0;
                  a_msb    <= a[WIDTH-1];
                  b_msb    <= b[WIDTH-1];
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               sum[{cnt, 2'b00} +: NIBBLE_W] <= slice_s;
               carry <= slice_cout;
               a_sh  <= a_sh >> NIBBLE_W;
               b_sh  <= b_sh >> NIBBLE_W;
               if (cnt == LAST) begin
                  // Top nibble: its carry and sign bit finish the result.
                  cout      <= slice_cout;
                  ovf       <= (a_msb == b_msb) && (slice_s[NIBBLE_W-1] != a_msb);
                  out_valid <= 1'b1;
                  cnt       <= '0;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cla_nibble_serial_ctrl.sv
// Bench for cla_nibble_serial_ctrl at WIDTH = 16, 4 and 32. Each width has
// its own driver pushing expected results into a queue and a monitor that
// pops and compares on every output handshake, checking latency, hold and
// release rules along the way.
module tb_cla_nibble_serial_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   function automatic void chk(input string nm, input bit ok, input string det);
      n_chk++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s: %s", nm, det);
      end
   endfunction

   for (genvar g = 0; g < 3; g++) begin : u
      localparam int W = (g == 0) ? 16 : (g == 1) ? 4 : 32;
      localparam int N = W / 4;

      logic         rst = 1'b0;
      logic         in_valid, in_ready, out_valid, out_ready;
      logic [W-1:0] a, b, sum;
      logic         cin, cout, ovf, busy;
      bit           rnd_mode = 1'b0;
      bit           done = 1'b0;
      int           cyc = 0;

      logic [W-1:0] qs[$];
      logic         qc[$];
      logic         qo[$];
      int           qa[$];

      cla_nibble_serial_ctrl #(.WIDTH(W)) dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .a         (a),
         .b         (b),
         .cin       (cin),
         .out_valid (out_valid),
         .out_ready (out_ready),
         .sum       (sum),
         .cout      (cout),
         .ovf       (ovf),
         .busy      (busy)
      );

      always @(posedge clk) cyc <= cyc + 1;

      task automatic tick();
         @(posedge clk);
         #1;
         if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
      endtask

      task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                          input logic [W-1:0] es, input logic ec, input logic eo);
         int n;
         n = 0;
         a = xa; b = xb; cin = xc; in_valid = 1'b1;
         while (!in_ready && n < 200) begin
            tick();
            n++;
         end
         if (!in_ready) begin
            chk($sformatf("w%0d_accept_timeout", W), 1'b0, "in_ready still 0, required 1");
            in_valid = 1'b0;
            return;
         end
         qs.push_back(es); qc.push_back(ec); qo.push_back(eo); qa.push_back(cyc + 1);
         tick();
         in_valid = 1'b0;
         a = 'x; b = 'x; cin = 1'bx;
      endtask

      task automatic drain();
         int n;
         n = 0;
         while (qs.size() != 0 && n < 500) begin
            tick();
            n++;
         end
         chk($sformatf("w%0d_drain", W), qs.size() == 0,
             $sformatf("pending=%0d, required 0", qs.size()));
      endtask

      task automatic reset_seq();
         in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
         #1 rst = 1'b1;
         #1;
         chk($sformatf("w%0d_reset_state", W),
             in_ready && !out_valid && !busy && sum == '0 && !cout && !ovf,
             $sformatf("rdy=%b vld=%b busy=%b sum=%h cout=%b ovf=%b, required 1 0 0 0 0 0",
                       in_ready, out_valid, busy, sum, cout, ovf));
         tick(); tick();
         rst = 1'b0;
      endtask

      task automatic random_run();
         logic [W-1:0] xa, xb;
         logic         xc;
         logic [W:0]   t;
         rnd_mode = 1'b1;
         for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            xa = W'($urandom);
            xb = W'($urandom);
            xc = 1'($urandom_range(0, 1));
            t  = {1'b0, xa} + {1'b0, xb} + (W+1)'(xc);
            send(xa, xb, xc, t[W-1:0], t[W],
                 (xa[W-1] == xb[W-1]) && (t[W-1] != xa[W-1]));
         end
         rnd_mode = 1'b0;
         out_ready = 1'b1;
         drain();
      endtask

      // Monitor
      initial begin
         logic         pov, por, pc, po, pcons;
         logic [W-1:0] ps;
         pov = 1'b0; por = 1'b0; pcons = 1'b0; pc = 1'b0; po = 1'b0; ps = '0;
         forever begin
            @(negedge clk);
            if (rst) begin
               qs.delete(); qc.delete(); qo.delete(); qa.delete();
               pov = 1'b0; por = 1'b0; pcons = 1'b0;
            end else begin
               if (pcons)
                  chk($sformatf("w%0d_release", W), !out_valid,
                      $sformatf("out_valid=%b, required 0", out_valid));
               if (pov && !por)
                  chk($sformatf("w%0d_hold", W),
                      out_valid && sum == ps && cout == pc && ovf == po,
                      $sformatf("vld=%b sum=%h cout=%b ovf=%b, required 1 %h %b %b",
                                out_valid, sum, cout, ovf, ps, pc, po));
               if (out_valid)
                  chk($sformatf("w%0d_done_flags", W), !in_ready && busy,
                      $sformatf("in_ready=%b busy=%b, required 0 1", in_ready, busy));
               if (out_valid && !pov) begin
                  if (qa.size() == 0)
                     chk($sformatf("w%0d_spurious_valid", W), 1'b0, "out_valid=1, required 0");
                  else
                     chk($sformatf("w%0d_latency", W), cyc == qa[0] + N,
                         $sformatf("edge %0d, required %0d", cyc, qa[0] + N));
               end
               if (out_valid && out_ready) begin
                  if (qs.size() == 0) begin
                     chk($sformatf("w%0d_unexpected_result", W), 1'b0, "result with empty queue");
                  end else begin
                     chk($sformatf("w%0d_result", W),
                         sum == qs[0] && cout == qc[0] && ovf == qo[0],
                         $sformatf("sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                                   sum, cout, ovf, qs[0], qc[0], qo[0]));
                     void'(qs.pop_front()); void'(qc.pop_front());
                     void'(qo.pop_front()); void'(qa.pop_front());
                  end
               end
               pcons = out_valid && out_ready;
               pov = out_valid; por = out_ready; ps = sum; pc = cout; po = ovf;
            end
         end
      end

      if (g == 0) begin : d
         task automatic directed();
            int n;
            out_ready = 1'b1;
            send(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0); drain();
            send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0); drain();
            send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1); drain();
            send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1); drain();

            // Backpressure with new operands offered while DONE
            out_ready = 1'b0;
            send(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
            n = 0;
            while (!out_valid && n < 50) begin
               tick();
               n++;
            end
            chk("bp_reach_done", out_valid, $sformatf("out_valid=%b, required 1", out_valid));
            a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
            repeat (6) tick();
            out_ready = 1'b1;
            send(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0); drain();

            // Asynchronous reset at cnt=2
            send(16'h5555, 16'h5555, 1'b0, 16'hAAAA, 1'b0, 1'b1);
            tick(); tick();
            chk("rst_pre_busy", busy, $sformatf("busy=%b, required 1", busy));
            #2 rst = 1'b1;
            #1;
            chk("rst_async", in_ready && !out_valid && !busy,
                $sformatf("in_ready=%b out_valid=%b busy=%b, required 1 0 0",
                          in_ready, out_valid, busy));
            tick();
            rst = 1'b0;
            send(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0); drain();
         endtask

         initial begin
            reset_seq();
            directed();
            random_run();
            done = 1'b1;
         end
      end else begin : r
         initial begin
            reset_seq();
            random_run();
            done = 1'b1;
         end
      end
   end

   initial begin
      int n;
      n = 0;
      while (!(u[0].done && u[1].done && u[2].done) && n < 60000) begin
         @(posedge clk);
         n++;
      end
      if (!(u[0].done && u[1].done && u[2].done))
         chk("global_timeout", 1'b0, $sformatf("done=%b%b%b, required 111",
             u[0].done, u[1].done, u[2].done));
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
